// File: rtl/adc_cfg_sequencer_if.sv
// Command/response handshake between the configuration sequencer and the SPI master.
// The master modport is the sequencer side; the slave modport is the SPI master side.
interface adc_cfg_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_word;
    logic        rsp_valid;
    logic [7:0]  rsp_data;

    modport master (
        output cmd_valid,
        output cmd_word,
        input  cmd_ready,
        input  rsp_valid,
        input  rsp_data
    );

    modport slave (
        input  cmd_valid,
        input  cmd_word,
        output cmd_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/adc_cfg_sequencer.sv
// AD9634 power-up sequencer: writes an external init table over SPI, commits it via the
// transfer register (0x0FF = 0x01), then optionally reads each entry back and compares it.
module adc_cfg_sequencer #(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned IDX_W       = 3,
    parameter int unsigned VERIFY      = 1,
    parameter int unsigned TIMEOUT     = 1023
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    output logic [IDX_W-1:0]     tbl_idx,
    input  logic [12:0]          tbl_addr,
    input  logic [7:0]           tbl_data,
    adc_cfg_sequencer_if.master  spi,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [1:0]           err_code,
    output logic [IDX_W-1:0]     fail_idx
);

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned WORD_W  = 24;
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [12:0]      XFER_ADDR = 13'h0FF;
    localparam logic [7:0]       XFER_DATA = 8'h01;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISMATCH = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ABORT    = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_WR_REQ,
        S_WR_WAIT,
        S_XFER_REQ,
        S_XFER_WAIT,
        S_RD_FETCH,
        S_RD_REQ,
        S_RD_WAIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic [WORD_W-1:0]  cmd_word_q, cmd_word_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [IDX_W-1:0]   fail_idx_q, fail_idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [7:0]         exp_q, exp_d;
    logic               abort_q, abort_d;

    logic               accept;
    logic               last;
    logic               timed_out;
    logic               abort_pend;
    logic               to_done;
    logic               aborted;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_word_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
            fail_idx_q  <= '0;
            cnt_q       <= '0;
            exp_q       <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_word_q  <= cmd_word_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
            fail_idx_q  <= fail_idx_d;
            cnt_q       <= cnt_d;
            exp_q       <= exp_d;
            abort_q     <= abort_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cmd_valid_d = cmd_valid_q;
        cmd_word_d  = cmd_word_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        err_code_d  = err_code_q;
        fail_idx_d  = fail_idx_q;
        cnt_d       = cnt_q;
        exp_d       = exp_q;
        abort_d     = abort_q;
        to_done     = 1'b0;
        aborted     = 1'b0;
        accept      = cmd_valid_q & spi.cmd_ready;
        last        = (idx_q == LAST_IDX);
        timed_out   = (cnt_q >= TO_LAST);
        abort_pend  = abort_q | abort;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_FETCH;
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                    fail_idx_d = '0;
                    abort_d    = 1'b0;
                end
            end

            S_FETCH, S_RD_FETCH: begin
                if (abort) begin
                    to_done = 1'b1;
                    aborted = 1'b1;
                end else begin
                    state_d = (state_q == S_FETCH) ? S_WR_REQ : S_RD_REQ;
                end
            end

            // First REQ cycle lets the sync ROM output settle before the command is loaded
            S_WR_REQ, S_XFER_REQ, S_RD_REQ: begin
                if (accept) begin
                    cmd_valid_d = 1'b0;
                    cnt_d       = '0;
                    abort_d     = abort;
                    if (state_q == S_WR_REQ) begin
                        state_d = S_WR_WAIT;
                    end else if (state_q == S_XFER_REQ) begin
                        state_d = S_XFER_WAIT;
                    end else begin
                        state_d = S_RD_WAIT;
                    end
                end else if (abort) begin
                    to_done = 1'b1;
                    aborted = 1'b1;
                end else if (!cmd_valid_q) begin
                    cmd_valid_d = 1'b1;
                    if (state_q == S_WR_REQ) begin
                        cmd_word_d = {1'b0, 2'b00, tbl_addr, tbl_data};
                    end else if (state_q == S_XFER_REQ) begin
                        cmd_word_d = {1'b0, 2'b00, XFER_ADDR, XFER_DATA};
                    end else begin
                        cmd_word_d = {1'b1, 2'b00, tbl_addr, 8'h00};
                        exp_d      = tbl_data;
                    end
                end
            end

            S_WR_WAIT, S_XFER_WAIT, S_RD_WAIT: begin
                if (spi.rsp_valid) begin
                    if (state_q == S_WR_WAIT) begin
                        if (last) begin
                            state_d = S_XFER_REQ;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = S_FETCH;
                        end
                    end else if (state_q == S_XFER_WAIT) begin
                        if (VERIFY != 0) begin
                            idx_d   = '0;
                            state_d = S_RD_FETCH;
                        end else begin
                            to_done = 1'b1;
                        end
                    end else begin
                        if (spi.rsp_data != exp_q) begin
                            error_d = 1'b1;
                            if (err_code_q == ERR_NONE) begin
                                err_code_d = ERR_MISMATCH;
                                fail_idx_d = idx_q;
                            end
                        end
                        if (last) begin
                            to_done = 1'b1;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = S_RD_FETCH;
                        end
                    end
                    if (abort_pend) begin
                        to_done = 1'b1;
                        aborted = 1'b1;
                    end
                end else if (timed_out) begin
                    error_d = 1'b1;
                    if (err_code_q == ERR_NONE) begin
                        err_code_d = ERR_TIMEOUT;
                        fail_idx_d = (state_q == S_XFER_WAIT) ? '1 : idx_q;
                    end
                    to_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (abort) begin
                        abort_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Common exit into DONE; an earlier recorded code is never overwritten by abort
        if (to_done) begin
            state_d     = S_DONE;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            cmd_valid_d = 1'b0;
            if (aborted) begin
                error_d = 1'b1;
                if (err_code_d == ERR_NONE) begin
                    err_code_d = ERR_ABORT;
                end
            end
        end
    end

    assign tbl_idx       = idx_q;
    assign spi.cmd_valid = cmd_valid_q;
    assign spi.cmd_word  = cmd_word_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_code      = err_code_q;
    assign fail_idx      = fail_idx_q;

endmodule

// File: tb/tb_adc_cfg_sequencer.sv
// Directed bench for adc_cfg_sequencer: instance 0 without read-back, instance 1 with
// read-back and a 50-cycle timeout, both driven by a behavioural SPI master and init ROM.
module tb_adc_cfg_sequencer;

    localparam int unsigned N  = 4;
    localparam int unsigned IW = 2;
    localparam logic [23:0] XFER_WORD = 24'h00FF01;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [1:0]        start;
    logic [1:0]        abort;
    logic [IW-1:0]     tbl_idx  [2];
    logic [12:0]       tbl_addr [2];
    logic [7:0]        tbl_data [2];
    logic [1:0]        busy;
    logic [1:0]        done;
    logic [1:0]        error;
    logic [1:0]        err_code [2];
    logic [IW-1:0]     fail_idx [2];

    logic [1:0]        cmd_valid;
    logic [1:0]        cmd_ready;
    logic [1:0]        rsp_valid;
    logic [23:0]       cmd_word [2];
    logic [7:0]        rsp_data [2];

    adc_cfg_sequencer_if if0 ();
    adc_cfg_sequencer_if if1 ();

    assign cmd_valid[0]  = if0.cmd_valid;
    assign cmd_word[0]   = if0.cmd_word;
    assign if0.cmd_ready = cmd_ready[0];
    assign if0.rsp_valid = rsp_valid[0];
    assign if0.rsp_data  = rsp_data[0];
    assign cmd_valid[1]  = if1.cmd_valid;
    assign cmd_word[1]   = if1.cmd_word;
    assign if1.cmd_ready = cmd_ready[1];
    assign if1.rsp_valid = rsp_valid[1];
    assign if1.rsp_data  = rsp_data[1];

    adc_cfg_sequencer #(.NUM_ENTRIES(N), .IDX_W(IW), .VERIFY(0), .TIMEOUT(1023)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
        .tbl_idx(tbl_idx[0]), .tbl_addr(tbl_addr[0]), .tbl_data(tbl_data[0]),
        .spi(if0), .busy(busy[0]), .done(done[0]), .error(error[0]),
        .err_code(err_code[0]), .fail_idx(fail_idx[0])
    );

    adc_cfg_sequencer #(.NUM_ENTRIES(N), .IDX_W(IW), .VERIFY(1), .TIMEOUT(50)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
        .tbl_idx(tbl_idx[1]), .tbl_addr(tbl_addr[1]), .tbl_data(tbl_data[1]),
        .spi(if1), .busy(busy[1]), .done(done[1]), .error(error[1]),
        .err_code(err_code[1]), .fail_idx(fail_idx[1])
    );

    logic [12:0] rom_a [N] = '{13'h014, 13'h016, 13'h018, 13'h008};
    logic [7:0]  rom_d [N] = '{8'h01, 8'h05, 8'h0E, 8'h00};
    logic [23:0] exp_w [9] = '{24'h001401, 24'h001605, 24'h00180E, 24'h000800, 24'h00FF01,
                               24'h801400, 24'h801600, 24'h801800, 24'h800800};

    // Synchronous init ROM, one read port per instance
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            tbl_addr[k] <= rom_a[tbl_idx[k]];
            tbl_data[k] <= rom_d[tbl_idx[k]];
        end
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SPI master model knobs and observations
    int          rdy_dly [2];
    int          rsp_dly [2];
    logic [1:0]  no_xfer;
    logic [3:0]  bad_en;
    logic [7:0]  bad_val [N];
    int          ph      [2];
    int          wcnt    [2];
    int          rcnt    [2];
    int          rd_n    [2];
    int          log_n   [2];
    int unsigned acc_cyc [2];
    logic [23:0] cur     [2];
    logic [23:0] log_w   [2][16];
    logic [7:0]  regs    [2][8192];

    // Behavioural SPI master, updated just after each rising edge
    always begin
        @(posedge clk);
        #2;
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                ph[k] = 0; wcnt[k] = 0; rcnt[k] = 0; rd_n[k] = 0; log_n[k] = 0;
                cmd_ready[k] = 1'b0; rsp_valid[k] = 1'b0; rsp_data[k] = 8'h00;
            end else begin
                if (start[k]) begin
                    log_n[k] = 0;
                    rd_n[k]  = 0;
                end
                rsp_valid[k] = 1'b0;
                case (ph[k])
                    0: begin
                        if (cmd_valid[k]) begin
                            if (wcnt[k] >= rdy_dly[k]) begin
                                cmd_ready[k] = 1'b1;
                                cur[k]       = cmd_word[k];
                                ph[k]        = 1;
                            end else begin
                                wcnt[k]++;
                            end
                        end else begin
                            wcnt[k] = 0;
                        end
                    end
                    1: begin
                        cmd_ready[k] = 1'b0;
                        wcnt[k]      = 0;
                        if (log_n[k] < 16) log_w[k][log_n[k]] = cur[k];
                        log_n[k]++;
                        acc_cyc[k] = cyc;
                        if (!cur[k][23]) regs[k][cur[k][20:8]] = cur[k][7:0];
                        rcnt[k] = 0;
                        ph[k]   = 2;
                    end
                    default: begin
                        rcnt[k]++;
                        if (rcnt[k] >= rsp_dly[k]) begin
                            ph[k] = 0;
                            if (!(no_xfer[k] && cur[k] == XFER_WORD)) begin
                                rsp_valid[k] = 1'b1;
                                rsp_data[k]  = 8'h00;
                                if (cur[k][23]) begin
                                    if (k == 1 && rd_n[k] < 4 && bad_en[rd_n[k]])
                                        rsp_data[k] = bad_val[rd_n[k]];
                                    else
                                        rsp_data[k] = regs[k][cur[k][20:8]];
                                    rd_n[k]++;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    int n_total = 0;
    int n_pass  = 0;
    int unsigned last_rsp_cyc;
    int unsigned done_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic pulse_start(input int k);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget, input string tag);
        int n = 0;
        while (!done[k] && n < budget) begin
            @(negedge clk);
            if (rsp_valid[k]) last_rsp_cyc = cyc;
            n++;
        end
        done_cyc = cyc;
        check(tag, 32'(done[k]), 32'd1);
    endtask

    initial begin
        int  n;
        bit  saw_valid;
        rst_n   = 1'b0;
        start   = '0;
        abort   = '0;
        rdy_dly = '{2, 2};
        rsp_dly = '{30, 30};
        no_xfer = '0;
        bad_en  = '0;
        bad_val = '{8'h00, 8'h00, 8'h0F, 8'hFF};
        repeat (3) @(negedge clk);

        check("rst_busy",      32'(busy),        32'd0);
        check("rst_done",      32'(done),        32'd0);
        check("rst_error",     32'(error),       32'd0);
        check("rst_cmd_valid", 32'(cmd_valid),   32'd0);
        check("rst_err_code",  32'(err_code[1]), 32'd0);
        check("rst_fail_idx",  32'(fail_idx[1]), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write pass plus transfer, no read-back
        pulse_start(0);
        check("t1_busy_start", 32'(busy[0]), 32'd1);
        wait_done(0, 2000, "t1_done");
        check("t1_busy_lag", done_cyc - last_rsp_cyc, 32'd1);
        check("t1_busy_end", 32'(busy[0]),  32'd0);
        check("t1_error",    32'(error[0]), 32'd0);
        check("t1_ncmd",     32'(log_n[0]), 32'd5);
        for (int i = 0; i < 5; i++) check($sformatf("t1_w%0d", i), 32'(log_w[0][i]), 32'(exp_w[i]));

        // Read-back with echoed data
        pulse_start(1);
        wait_done(1, 4000, "t2_done");
        check("t2_ncmd",     32'(log_n[1]),    32'd9);
        for (int i = 0; i < 9; i++) check($sformatf("t2_w%0d", i), 32'(log_w[1][i]), 32'(exp_w[i]));
        check("t2_err_code", 32'(err_code[1]), 32'd0);
        check("t2_error",    32'(error[1]),    32'd0);

        // Read-back with bad data at indices 2 and 3
        bad_en = 4'b1100;
        pulse_start(1);
        wait_done(1, 4000, "t3_done");
        check("t3_ncmd",     32'(log_n[1]),    32'd9);
        check("t3_err_code", 32'(err_code[1]), 32'd1);
        check("t3_fail_idx", 32'(fail_idx[1]), 32'd2);
        check("t3_error",    32'(error[1]),    32'd1);
        bad_en = '0;

        // Transfer write never answered
        no_xfer[1] = 1'b1;
        pulse_start(1);
        wait_done(1, 4000, "t4_done");
        check("t4_latency",  done_cyc - acc_cyc[1], 32'd50);
        check("t4_err_code", 32'(err_code[1]),  32'd2);
        check("t4_fail_idx", 32'(fail_idx[1]),  32'd3);
        check("t4_error",    32'(error[1]),     32'd1);
        check("t4_cmd_valid", 32'(cmd_valid[1]), 32'd0);
        check("t4_ncmd",     32'(log_n[1]),     32'd5);
        no_xfer[1] = 1'b0;

        // Back-pressure on the first write, then abort
        rdy_dly[1] = 1000;
        pulse_start(1);
        n = 0;
        while (!cmd_valid[1] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t5_valid", 32'(cmd_valid[1]), 32'd1);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t5_word%0d", i), 32'(cmd_word[1]), 32'h001401);
            @(negedge clk);
        end
        abort[1] = 1'b1;
        @(negedge clk);
        abort[1] = 1'b0;
        check("t5_done",      32'(done[1]),      32'd1);
        check("t5_err_code",  32'(err_code[1]),  32'd3);
        check("t5_cmd_valid", 32'(cmd_valid[1]), 32'd0);
        saw_valid = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (cmd_valid[1]) saw_valid = 1'b1;
        end
        check("t5_no_cmd", 32'(saw_valid),  32'd0);
        check("t5_ncmd",   32'(log_n[1]),   32'd0);
        rdy_dly[1] = 2;

        // Reset during the second write's response wait
        pulse_start(1);
        n = 0;
        while (log_n[1] < 2 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t6_reached", 32'(log_n[1]), 32'd2);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_busy",      32'(busy[1]),      32'd0);
        check("t6_done",      32'(done[1]),      32'd0);
        check("t6_cmd_valid", 32'(cmd_valid[1]), 32'd0);
        check("t6_tbl_idx",   32'(tbl_idx[1]),   32'd0);
        check("t6_err_code",  32'(err_code[1]),  32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start(1);
        n = 0;
        while (log_n[1] < 1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t6_first_word", 32'(log_w[1][0]), 32'h001401);
        wait_done(1, 4000, "t6_done");
        check("t6_error", 32'(error[1]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
